gray_counter_n: RTL and testbench



---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_next.sv | 75 +++++++
 rtl/gray_counter_n.sv | 67 ++++++
 tb/tb_gray_counter_n.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and width limits for the Gray counter and pointer synchronisers.
// Optional build macro honoured by users of this package: GRAY_COUNTER_SATURATE_EN.
package gray_pkg;

   localparam int GRAY_WIDTH_MIN = 2;
   localparam int GRAY_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_LOAD,
      OP_UP,
      OP_DOWN
   } step_op_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] w);
      return w ^ (w >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] w);
      logic [31:0] b;
      b[31] = w[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ w[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_next.sv
// Combinational next-state logic for gray_counter_n: load/step/hold selection, wrap or saturate.
// Define GRAY_COUNTER_SATURATE_EN to clamp at the ends instead of wrapping.
module gray_next
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] nxt_bin,
   output logic [WIDTH-1:0] nxt_gray,
   output logic             nxt_tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

   step_op_e w_op;
   logic     w_atMax;
   logic     w_atZero;

   assign w_atMax  = (cnt == MAX_VAL);
   assign w_atZero = (cnt == '0);

   // Load outranks counting; up is only looked at when a step is actually taken.
   always_comb begin
      w_op = OP_HOLD;
      if (load) begin
         w_op = OP_LOAD;
      end else if (en) begin
         w_op = up ? OP_UP : OP_DOWN;
      end
   end

   // tc flags the step that wraps (or, when saturating, the step that lands on the end value).
   always_comb begin
      nxt_bin = cnt;
      nxt_tc  = 1'b0;
      unique case (w_op)
         OP_LOAD: begin
            nxt_bin = load_val;
         end
         OP_UP: begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (!w_atMax) begin
               nxt_bin = cnt + ONE_VAL;
               nxt_tc  = (cnt == (MAX_VAL - ONE_VAL));
            end
`else
            nxt_bin = cnt + ONE_VAL;
            nxt_tc  = w_atMax;
`endif
         end
         OP_DOWN: begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (!w_atZero) begin
               nxt_bin = cnt - ONE_VAL;
               nxt_tc  = (cnt == ONE_VAL);
            end
`else
            nxt_bin = cnt - ONE_VAL;
            nxt_tc  = w_atZero;
`endif
         end
         default: begin
         end
      endcase
   end

   assign nxt_gray = WIDTH'(bin2gray(32'(nxt_bin)));

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter with enable, direction, load, binary mirror and terminal-count pulse.
// Build option: define GRAY_COUNTER_SATURATE_EN for saturating instead of wrapping ends.
module gray_counter_n
   import gray_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             tc
);

   if ((WIDTH < GRAY_WIDTH_MIN) || (WIDTH > GRAY_WIDTH_MAX)) begin : g_badWidth
      $fatal(1, "gray_counter_n: WIDTH=%0d outside %0d..%0d", WIDTH, GRAY_WIDTH_MIN, GRAY_WIDTH_MAX);
   end
   if (longint'(INIT) >= (longint'(1) << WIDTH)) begin : g_badInit
      $fatal(1, "gray_counter_n: INIT=%0d does not fit in %0d bits", INIT, WIDTH);
   end

   localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] INIT_GRAY = WIDTH'(bin2gray(32'(INIT_BIN)));

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_tc;
   logic [WIDTH-1:0] w_nxtBin;
   logic [WIDTH-1:0] w_nxtGray;
   logic             w_nxtTc;

   gray_next #(
      .WIDTH(WIDTH)
   ) u_next (
      .cnt     (r_bin),
      .en      (en),
      .up      (up),
      .load    (load),
      .load_val(load_val),
      .nxt_bin (w_nxtBin),
      .nxt_gray(w_nxtGray),
      .nxt_tc  (w_nxtTc)
   );

   // Gray is registered from the next binary value so the output bus never glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bin  <= INIT_BIN;
         r_gray <= INIT_GRAY;
         r_tc   <= 1'b0;
      end else begin
         r_bin  <= w_nxtBin;
         r_gray <= w_nxtGray;
         r_tc   <= w_nxtTc;
      end
   end

   assign bin_out  = r_bin;
   assign gray_out = r_gray;
   assign tc       = r_tc;

endmodule

// File: tb/tb_gray_counter_n.sv
// Self-checking bench for gray_counter_n: directed vector table on WIDTH=4, async reset on INIT=5,
// and a randomized WIDTH=8 run against an arithmetic reference model.
module tb_gray_counter_n;

   typedef struct {
      logic       en;
      logic       up;
      logic       load;
      logic [3:0] loadVal;
      logic [3:0] expGray;
      logic [3:0] expBin;
      logic       expTc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstN4 = 1'b1;
   logic       rstN5 = 1'b1;
   logic       rstN8 = 1'b1;
   logic       en4 = 1'b0;
   logic       up4 = 1'b0;
   logic       load4 = 1'b0;
   logic [3:0] loadVal4 = '0;
   logic [3:0] gray4, bin4, gray5, bin5;
   logic       tc4, tc5;
   logic       en8 = 1'b0;
   logic       up8 = 1'b0;
   logic       load8 = 1'b0;
   logic [7:0] loadVal8 = '0;
   logic [7:0] gray8, bin8;
   logic       tc8;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   logic [3:0] grayOf[16];

   always #5 clk = ~clk;

   gray_counter_n #(.WIDTH(4), .INIT(0)) dut4 (
      .clk(clk), .reset_n(rstN4), .en(en4), .up(up4), .load(load4), .load_val(loadVal4),
      .gray_out(gray4), .bin_out(bin4), .tc(tc4));

   gray_counter_n #(.WIDTH(4), .INIT(5)) dut5 (
      .clk(clk), .reset_n(rstN5), .en(en4), .up(up4), .load(load4), .load_val(loadVal4),
      .gray_out(gray5), .bin_out(bin5), .tc(tc5));

   gray_counter_n #(.WIDTH(8), .INIT(0)) dut8 (
      .clk(clk), .reset_n(rstN8), .en(en8), .up(up8), .load(load8), .load_val(loadVal8),
      .gray_out(gray8), .bin_out(bin8), .tc(tc8));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic e, input logic u, input logic l, input logic [3:0] lv,
                         input logic [3:0] eg, input logic [3:0] eb, input logic et);
      vec_t v;
      v.en = e; v.up = u; v.load = l; v.loadVal = lv;
      v.expGray = eg; v.expBin = eb; v.expTc = et;
      vecs.push_back(v);
   endtask

   // Drive between edges, then sample 1 ns after the capturing edge.
   task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [3:0] lv);
      @(negedge clk);
      en4 = e; up4 = u; load4 = l; loadVal4 = lv;
      @(posedge clk);
      #1;
   endtask

   // Reference model for the WIDTH=8 instance: plain integer arithmetic on the count.
   int mBin = 0;
   int mTc = 0;
   localparam int M_MAX = 255;

   task automatic modelStep(input bit e, input bit u, input bit l, input int lv);
      if (l) begin
         mBin = lv;
         mTc  = 0;
      end else if (e) begin
         if (u) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (mBin == M_MAX) mTc = 0;
            else begin mBin = mBin + 1; mTc = (mBin == M_MAX) ? 1 : 0; end
`else
            mTc  = (mBin == M_MAX) ? 1 : 0;
            mBin = (mBin + 1) % (M_MAX + 1);
`endif
         end else begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (mBin == 0) mTc = 0;
            else begin mBin = mBin - 1; mTc = (mBin == 0) ? 1 : 0; end
`else
            mTc  = (mBin == 0) ? 1 : 0;
            mBin = (mBin + M_MAX) % (M_MAX + 1);
`endif
         end
      end else begin
         mTc = 0;
      end
   endtask

   function automatic int decodeGray(input logic [7:0] g);
      int   b;
      logic acc;
      b   = 0;
      acc = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         acc = acc ^ g[i];
         if (acc) b = b | (1 << i);
      end
      return b;
   endfunction

   initial begin
      int   prevBin;
      logic [7:0] prevGray;
      int   lv;
      bit   e, u, l;

      grayOf = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

`ifdef GRAY_COUNTER_SATURATE_EN
      for (int i = 0; i < 15; i++) addVec(1, 1, 0, 0, grayOf[i+1], 4'(i + 1), (i == 14));
      for (int i = 0; i < 3; i++)  addVec(1, 1, 0, 0, 4'h8, 4'd15, 0);
      addVec(1, 1, 1, 4'd0, 4'h0, 4'd0, 0);
      addVec(1, 0, 0, 0, 4'h0, 4'd0, 0);
      addVec(1, 0, 0, 0, 4'h0, 4'd0, 0);
      addVec(1, 1, 0, 0, 4'h1, 4'd1, 0);
      addVec(1, 0, 0, 0, 4'h0, 4'd0, 1);
      addVec(1, 0, 0, 0, 4'h0, 4'd0, 0);
      addVec(0, 0, 1, 4'd15, 4'h8, 4'd15, 0);
      addVec(1, 0, 0, 0, 4'h9, 4'd14, 0);
      addVec(1, 1, 0, 0, 4'h8, 4'd15, 1);
      addVec(0, 1, 0, 0, 4'h8, 4'd15, 0);
`else
      for (int i = 0; i < 16; i++) addVec(1, 1, 0, 0, grayOf[(i + 1) % 16], 4'((i + 1) % 16), (i == 15));
      addVec(1, 0, 0, 0, 4'h8, 4'd15, 1);
      addVec(1, 0, 0, 0, 4'h9, 4'd14, 0);
      for (int i = 0; i < 5; i++) addVec(0, 1, 0, 0, 4'h9, 4'd14, 0);
      addVec(1, 1, 1, 4'd10, 4'hF, 4'd10, 0);
      addVec(1, 1, 0, 0, 4'hE, 4'd11, 0);
      addVec(1, 0, 0, 0, 4'hF, 4'd10, 0);
      addVec(1, 1, 0, 0, 4'hE, 4'd11, 0);
      addVec(0, 0, 1, 4'd15, 4'h8, 4'd15, 0);
      addVec(1, 1, 0, 0, 4'h0, 4'd0, 1);
      addVec(1, 1, 0, 0, 4'h1, 4'd1, 0);
      addVec(0, 1, 1, 4'd0, 4'h0, 4'd0, 0);
      addVec(1, 0, 0, 0, 4'h8, 4'd15, 1);
      addVec(0, 0, 0, 0, 4'h8, 4'd15, 0);
`endif

      #1;
      rstN4 = 1'b0; rstN5 = 1'b0; rstN8 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset dut4 gray", 32'(gray4), 32'h0);
      checkOutput("reset dut4 bin",  32'(bin4),  32'h0);
      checkOutput("reset dut4 tc",   32'(tc4),   32'h0);
      checkOutput("reset dut5 gray", 32'(gray5), 32'h7);
      checkOutput("reset dut5 bin",  32'(bin5),  32'h5);
      checkOutput("reset dut5 tc",   32'(tc5),   32'h0);
      checkOutput("reset dut8 gray", 32'(gray8), 32'h0);
      checkOutput("reset dut8 bin",  32'(bin8),  32'h0);

      @(negedge clk);
      rstN4 = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].loadVal);
         checkOutput($sformatf("vec%0d gray", i), 32'(gray4), 32'(vecs[i].expGray));
         checkOutput($sformatf("vec%0d bin", i),  32'(bin4),  32'(vecs[i].expBin));
         checkOutput($sformatf("vec%0d tc", i),   32'(tc4),   32'(vecs[i].expTc));
      end

      // Asynchronous reset mid-count on the INIT=5 instance.
      @(negedge clk);
      rstN5 = 1'b1;
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 1, 0, 0);
      checkOutput("init5 count bin",  32'(bin5),  32'h7);
      checkOutput("init5 count gray", 32'(gray5), 32'h4);
      #2;
      rstN5 = 1'b0;
      #1;
      checkOutput("async reset bin",  32'(bin5),  32'h5);
      checkOutput("async reset gray", 32'(gray5), 32'h7);
      checkOutput("async reset tc",   32'(tc5),   32'h0);
      @(posedge clk);
      #1;
      checkOutput("held reset bin", 32'(bin5), 32'h5);
      @(negedge clk);
      rstN5 = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("first step after reset bin",  32'(bin5),  32'h6);
      checkOutput("first step after reset gray", 32'(gray5), 32'h5);

      // Randomized WIDTH=8 run against the arithmetic model.
      @(negedge clk);
      rstN8 = 1'b1;
      mBin = 0;
      mTc  = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         e = ($urandom_range(0, 3) != 0);
         u = ($urandom_range(0, 1) != 0);
         l = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 4))
            0: lv = 0;
            1: lv = 1;
            2: lv = 254;
            3: lv = 255;
            default: lv = int'($urandom_range(0, 255));
         endcase
         en8 = e; up8 = u; load8 = l; loadVal8 = 8'(lv);
         prevBin  = mBin;
         prevGray = gray8;
         modelStep(e, u, l, lv);
         @(posedge clk);
         #1;
         checkOutput($sformatf("rnd%0d bin", n),  32'(bin8),  32'(mBin));
         checkOutput($sformatf("rnd%0d gray", n), 32'(gray8), 32'(mBin ^ (mBin >> 1)));
         checkOutput($sformatf("rnd%0d tc", n),   32'(tc8),   32'(mTc));
         checkOutput($sformatf("rnd%0d decode", n), 32'(decodeGray(gray8)), 32'(mBin));
         if (!l) begin
            checkOutput($sformatf("rnd%0d hamming", n), 32'($countones(gray8 ^ prevGray)),
                        32'((mBin != prevBin) ? 1 : 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
